// File: rtl/aes_key_schedule_gen.sv
// AES key-schedule generator for 128/192/256-bit keys: expands the cipher key one
// 32-bit word per cycle and streams round keys 0..NR over a valid/ready handshake.
module aes_key_schedule_gen #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [KEY_BITS-1:0] key_i,
    output logic [127:0]        rk_o,
    output logic                rk_valid_o,
    input  logic                rk_ready_i,
    output logic [3:0]          rk_idx_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int NK    = KEY_BITS / 32;
    localparam int NR    = NK + 6;
    localparam int TOTAL = 4 * (NR + 1);

    localparam logic [5:0] TotalWords = 6'(TOTAL);
    localparam logic [5:0] NkWords    = 6'(NK);
    localparam logic [2:0] NkLast     = 3'(NK - 1);
    localparam logic [3:0] NrIdx      = 4'(NR);

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("aes_key_schedule_gen: KEY_BITS must be 128, 192 or 256");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_e                 state_q, state_d;
    logic [NK-1:0][31:0]    win_q, win_d;      // win_q[0] = w[i-NK], win_q[NK-1] = w[i-1]
    logic [5:0]             word_cnt_q, word_cnt_d;
    logic [2:0]             word_mod_q, word_mod_d;
    logic [7:0]             rcon_q, rcon_d;
    logic [95:0]            part_q, part_d;
    logic [1:0]             part_cnt_q, part_cnt_d;
    logic [3:0]             key_cnt_q, key_cnt_d;
    logic [127:0]           rk_q, rk_d;
    logic                   rk_valid_q, rk_valid_d;
    logic [3:0]             rk_idx_q, rk_idx_d;

    logic [31:0]            prev_word, temp_word, new_word;
    logic                   gen_en;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            win_q      <= '0;
            word_cnt_q <= '0;
            word_mod_q <= '0;
            rcon_q     <= 8'h01;
            part_q     <= '0;
            part_cnt_q <= '0;
            key_cnt_q  <= '0;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
            rk_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            word_cnt_q <= word_cnt_d;
            word_mod_q <= word_mod_d;
            rcon_q     <= rcon_d;
            part_q     <= part_d;
            part_cnt_q <= part_cnt_d;
            key_cnt_q  <= key_cnt_d;
            rk_q       <= rk_d;
            rk_valid_q <= rk_valid_d;
            rk_idx_q   <= rk_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        word_cnt_d = word_cnt_q;
        word_mod_d = word_mod_q;
        rcon_d     = rcon_q;
        part_d     = part_q;
        part_cnt_d = part_cnt_q;
        key_cnt_d  = key_cnt_q;
        rk_d       = rk_q;
        rk_valid_d = rk_valid_q;
        rk_idx_d   = rk_idx_q;

        prev_word = win_q[NK-1];
        temp_word = prev_word;
        if (word_mod_q == 3'd0) begin
            temp_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon_q, 24'h0};
        end else if (NK == 8 && word_mod_q == 3'd4) begin
            temp_word = sub_word(prev_word);
        end
        // The first NK words rotate the loaded key through the window unchanged.
        new_word = (word_cnt_q < NkWords) ? win_q[0] : (win_q[0] ^ temp_word);

        gen_en = (state_q == StExpand) && (word_cnt_q < TotalWords) &&
                 (!rk_valid_q || rk_ready_i);

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    for (int j = 0; j < NK; j++) begin
                        win_d[j] = key_i[KEY_BITS-1-32*j -: 32];
                    end
                    word_cnt_d = '0;
                    word_mod_d = '0;
                    rcon_d     = 8'h01;
                    part_cnt_d = '0;
                    key_cnt_d  = '0;
                    state_d    = StExpand;
                end
            end
            StExpand: begin
                if (rk_valid_q && rk_ready_i) begin
                    rk_valid_d = 1'b0;
                    if (rk_idx_q == NrIdx) begin
                        state_d = StDone;
                    end
                end
                if (gen_en) begin
                    for (int j = 0; j < NK - 1; j++) begin
                        win_d[j] = win_q[j+1];
                    end
                    win_d[NK-1] = new_word;
                    word_cnt_d  = word_cnt_q + 6'd1;
                    word_mod_d  = (word_mod_q == NkLast) ? 3'd0 : word_mod_q + 3'd1;
                    if (word_mod_q == 3'd0 && word_cnt_q >= NkWords) begin
                        rcon_d = xtime(rcon_q);
                    end
                    if (part_cnt_q == 2'd3) begin
                        rk_d       = {part_q, new_word};
                        rk_valid_d = 1'b1;
                        rk_idx_d   = key_cnt_q;
                        key_cnt_d  = key_cnt_q + 4'd1;
                        part_cnt_d = '0;
                    end else begin
                        part_d     = {part_q[63:0], new_word};
                        part_cnt_d = part_cnt_q + 2'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rk_o       = rk_q;
    assign rk_valid_o = rk_valid_q;
    assign rk_idx_o   = rk_idx_q;
    assign busy_o     = (state_q == StExpand);
    assign done_o     = (state_q == StDone);

endmodule

// File: tb/tb_aes_key_schedule_gen.sv
// Self-checking bench for aes_key_schedule_gen: one instance per key size, compared
// against a FIPS-197 reference expansion built from a computed S-box.
module tb_aes_key_schedule_gen;

    localparam logic [255:0] KEY128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KEY192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_s [3];
    logic         ready_s [3];
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;
    logic [127:0] rk_w    [3];
    logic         valid_w [3];
    logic [3:0]   idx_w   [3];
    logic         busy_w  [3];
    logic         done_w  [3];

    int checks = 0;
    int failures = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [15];
    logic [127:0] got_rk [15];

    always #5 clk = ~clk;

    aes_key_schedule_gen #(.KEY_BITS(128)) u_dut128 (
        .clk_i(clk), .rst_n(rst_n), .start_i(start_s[0]), .key_i(key128),
        .rk_o(rk_w[0]), .rk_valid_o(valid_w[0]), .rk_ready_i(ready_s[0]),
        .rk_idx_o(idx_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0])
    );
    aes_key_schedule_gen #(.KEY_BITS(192)) u_dut192 (
        .clk_i(clk), .rst_n(rst_n), .start_i(start_s[1]), .key_i(key192),
        .rk_o(rk_w[1]), .rk_valid_o(valid_w[1]), .rk_ready_i(ready_s[1]),
        .rk_idx_o(idx_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1])
    );
    aes_key_schedule_gen #(.KEY_BITS(256)) u_dut256 (
        .clk_i(clk), .rst_n(rst_n), .start_i(start_s[2]), .key_i(key256),
        .rk_o(rk_w[2]), .rk_valid_o(valid_w[2]), .rk_ready_i(ready_s[2]),
        .rk_idx_o(idx_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2])
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int j = 0; j < 8; j++) begin
            if (b[j]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_m[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // Reference expansion; key is right-aligned in 256 bits.
    task automatic expand_ref(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr = nk + 6;
        for (int j = 0; j < nk; j++) w[j] = key[32*(nk-1-j) +: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int n = 1; n < i / nk; n++) rc = gmul(rc, 8'h02);
                t = sub_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_m(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k <= nr; k++) exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    // Entered at a negedge. mode 0: ready high; 1: 7-cycle stall on rk3 then random;
    // 2: random ready; 3: ready high plus an ignored start pulse with another key.
    task automatic run_key(input int d, input int nk, input logic [255:0] key,
                           input int mode, input string tag);
        int k = 0;
        int cyc = 0;
        int stall_left = 7;
        int nr = nk + 6;
        logic rdy;
        logic stalled = 1'b0;
        logic [127:0] hold_rk = '0;
        logic [3:0]   hold_idx = '0;
        expand_ref(key, nk);
        case (d)
            0: key128 = key[127:0];
            1: key192 = key[191:0];
            default: key256 = key;
        endcase
        start_s[d] = 1'b1;
        @(posedge clk);
        #1;
        start_s[d] = 1'b0;
        chk({tag, "_busy_after_start"}, 128'(busy_w[d]), 128'd1);
        while (k <= nr && cyc < 2000) begin
            @(negedge clk);
            case (mode)
                1: begin
                    if (k < 3) rdy = 1'b1;
                    else if (k == 3 && stall_left > 0) begin
                        rdy = 1'b0;
                        if (valid_w[d]) stall_left--;
                    end else rdy = 1'($urandom_range(0, 1));
                end
                2: rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b1;
            endcase
            if (mode == 3) begin
                start_s[d] = (cyc == 10);
                if (cyc == 10) key128 = ~key[127:0];
            end
            ready_s[d] = rdy;
            if (stalled) begin
                chk({tag, "_stall_valid"}, 128'(valid_w[d]), 128'd1);
                chk({tag, "_stall_rk"}, rk_w[d], hold_rk);
                chk({tag, "_stall_idx"}, 128'(idx_w[d]), 128'(hold_idx));
            end
            stalled = 1'b0;
            if (valid_w[d]) begin
                if (rdy) begin
                    chk($sformatf("%s_rk%0d", tag, k), rk_w[d], exp_rk[k]);
                    chk($sformatf("%s_idx%0d", tag, k), 128'(idx_w[d]), 128'(k));
                    if (mode == 0 || mode == 3)
                        chk($sformatf("%s_time%0d", tag, k), 128'(cyc), 128'(4 * (k + 1)));
                    got_rk[k] = rk_w[d];
                    k++;
                end else begin
                    stalled  = 1'b1;
                    hold_rk  = rk_w[d];
                    hold_idx = idx_w[d];
                end
            end
            @(posedge clk);
            cyc++;
        end
        start_s[d] = 1'b0;
        ready_s[d] = 1'b1;
        chk({tag, "_all_keys_before_timeout"}, 128'(k), 128'(nr + 1));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 128'(done_w[d]), 128'd1);
        chk({tag, "_valid_low_in_done"}, 128'(valid_w[d]), 128'd0);
        @(negedge clk);
        chk({tag, "_done_single"}, 128'(done_w[d]), 128'd0);
        chk({tag, "_idle_not_busy"}, 128'(busy_w[d]), 128'd0);
    endtask

    initial begin
        logic [255:0] rkey;
        int n;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            ready_s[d] = 1'b1;
        end
        key128 = '0;
        key192 = '0;
        key256 = '0;
        build_sbox();
        #2;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_rk_%0d", d), rk_w[d], 128'd0);
            chk($sformatf("reset_valid_%0d", d), 128'(valid_w[d]), 128'd0);
            chk($sformatf("reset_idx_%0d", d), 128'(idx_w[d]), 128'd0);
            chk($sformatf("reset_busy_%0d", d), 128'(busy_w[d]), 128'd0);
            chk($sformatf("reset_done_%0d", d), 128'(done_w[d]), 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_key(0, 4, KEY128, 0, "aes128");
        chk("aes128_vec_rk0", got_rk[0], KEY128[127:0]);
        chk("aes128_vec_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("aes128_vec_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_key(1, 6, KEY192, 0, "aes192");
        chk("aes192_vec_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
        run_key(2, 8, KEY256, 0, "aes256");
        chk("aes256_vec_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // Back-to-back runs on the 128-bit instance start in the first IDLE cycle.
        run_key(0, 4, KEY128, 1, "bp");
        chk("bp_vec_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_key(0, 4, KEY128, 3, "midstart");
        chk("midstart_vec_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 3; d++) begin
                rkey = {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
                n = 4 + 2 * d;
                rkey = rkey & ((256'd1 << (32 * n)) - 256'd1);
                run_key(d, n, rkey, 2, $sformatf("rand%0d_%0d", r, d));
            end
        end

        // Asynchronous reset in the middle of an expansion.
        key128 = KEY128[127:0];
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        n = 0;
        while (!(valid_w[0] && idx_w[0] == 4'd5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_rk5", 128'(idx_w[0]), 128'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_rk", rk_w[0], 128'd0);
        chk("rst_async_valid", 128'(valid_w[0]), 128'd0);
        chk("rst_async_idx", 128'(idx_w[0]), 128'd0);
        chk("rst_async_busy", 128'(busy_w[0]), 128'd0);
        chk("rst_async_done", 128'(done_w[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_no_partial_valid", 128'(valid_w[0]), 128'd0);
        chk("rst_no_partial_busy", 128'(busy_w[0]), 128'd0);
        run_key(0, 4, KEY128, 0, "after_rst");
        chk("after_rst_vec_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule_gen.md
Name: aes_key_schedule_gen

Overview:
- Parametrised AES key-schedule generator for AES-128, AES-192 and AES-256.
- It is the successor of the single-round G-function/XOR stage. It takes a cipher key on a start handshake and expands it one 32-bit word per cycle, following FIPS-197 (RotWord, SubWord, Rcon, XOR with word i-Nk).
- It emits every round key, 0..NR, as a 128-bit word on a valid/ready stream to the cipher datapath.
- It sits between the key register and the round pipeline, and replaces the fixed 128-bit, single-round expansion.

Parameters:
- KEY_BITS, 128, cipher key width. Legal values are 128, 192 and 256; any other value is an elaboration error.
- NK (localparam), KEY_BITS/32, number of key words: 4, 6 or 8.
- NR (localparam), NK+6, number of rounds: 10, 12 or 14.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  request a new expansion. Sampled only in IDLE; ignored otherwise.
- key_i  in  KEY_BITS  cipher key. w0 = key_i[KEY_BITS-1 -: 32]. Sampled on the edge that accepts start_i.
- rk_o  out  128  round key, {w[4k], w[4k+1], w[4k+2], w[4k+3]}, w[4k] in the MSBs.
- rk_valid_o  out  1  rk_o/rk_idx_o are valid.
- rk_ready_i  in  1  consumer accepts the round key when rk_valid_o && rk_ready_i.
- rk_idx_o  out  4  round index k, 0..NR.
- busy_o  out  1  high from the accepting edge until done_o.
- done_o  out  1  one-cycle pulse after the final round key is accepted.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - rk_o=0, rk_valid_o=0, rk_idx_o=0, busy_o=0, done_o=0.
  - Word counter=0, Rcon=8'h01, window and collector cleared.
  - Reset asserted mid-expansion aborts immediately. No partial key is emitted after release.
- State machine has three states: IDLE, EXPAND, DONE.
  - IDLE -> EXPAND on start_i. key_i is loaded into an NK-word window, the word counter i is set to 0, and Rcon is set to 8'h01.
  - EXPAND -> DONE when round key NR is accepted.
  - DONE -> IDLE unconditionally after one cycle. done_o=1 only in DONE.
- Word generation: one word per cycle in EXPAND, allowed when the collector holds fewer than 4 words OR is being drained in the same cycle.
  - For i < NK, the word is key word i.
  - Otherwise temp = w[i-1], then:
    - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}. Rcon then advances by xtime (multiply by 2 in GF(2^8), reduction 8'h1B).
    - Else if NK==8 and i mod 8 == 4: temp = SubWord(temp).
    - w[i] = w[i-NK] ^ temp.
  - S-box is a combinational lookup: 4 parallel byte lookups, no extra latency.
  - The window shifts by one word per generated word. Total words generated = 4*(NR+1), i.e. 44, 52 or 60.
- Collector: a 4-word buffer, independent of the NK window.
  - When it fills, rk_o is registered, rk_valid_o=1 and rk_idx_o=k.
  - Handles AES-192 round keys that straddle window boundaries.
- Handshake:
  - rk_o, rk_valid_o and rk_idx_o are held stable while rk_valid_o && !rk_ready_i.
  - Generation stalls during the stall; i and Rcon are frozen.
  - On acceptance, the next word enters the collector in that same cycle.
- Latency and throughput:
  - With rk_ready_i held high, round key 0 is valid 4 cycles after the accepting edge.
  - Each subsequent round key follows every 4 cycles.
  - Round key NR is accepted, then done_o pulses on the following cycle, then IDLE.
- start_i while busy_o=1 is ignored. The current expansion continues unchanged.
- Back-to-back runs: start_i is accepted on the first IDLE cycle after DONE.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready_i=1:
  - rk0 equals the key.
  - rk1 = a0fafe1788542cb123a339392a6c7605.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - 11 keys, spaced 4 cycles apart; done_o pulses once.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - rk12 = e98ba06f448c773c8ecc720401002202.
  - 13 keys, rk_idx_o 0..12 in order.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - rk14 = fe4890d1e6188d0b046df344706c631e.
  - Exercises the i mod 8 == 4 SubWord path.
- Backpressure, AES-128: hold rk_ready_i=0 for 7 cycles on rk3, then randomly toggle it.
  - rk_o and rk_idx_o stay stable while stalled.
  - All 11 keys still match the vector.
  - No key is dropped or duplicated.
- Robustness, AES-128:
  - Pulse start_i mid-expansion with a different key: it is ignored and the outputs match the first key.
  - Assert rst_n=0 at rk5: all outputs return to 0 asynchronously.
  - After release, a new start produces a correct rk0..rk10 sequence.
